// File: rtl/alu_mc_pkg.sv
// alu_defs: shared definitions for the multi-cycle MIPS ALU and its control
// decoder. Holds the width defaults, the operation codes and the FSM state
// encoding.
package alu_defs;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 4;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_NOR   = 4'd4;
  localparam logic [3:0] OP_SLTU  = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result bundle between the ALU control side (master)
// and the multi-cycle ALU (slave).
//   iValid/oReady : request handshake, accepted when both are high
//   iOp/iA/iB     : operation code and operands, sampled on accept
//   oValid        : one-cycle pulse when the result outputs are updated
//   oALU/oHi/oLo  : result, HI and LO registers
//   oZero/oOverflow/oDivZero : result flags
interface alu_mc_if
  import alu_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
);
  logic              iValid;
  logic              oReady;
  logic [OP_W-1:0]   iOp;
  logic [DATA_W-1:0] iA;
  logic [DATA_W-1:0] iB;
  logic              oValid;
  logic [DATA_W-1:0] oALU;
  logic [DATA_W-1:0] oHi;
  logic [DATA_W-1:0] oLo;
  logic              oZero;
  logic              oOverflow;
  logic              oDivZero;

  modport master (
    output iValid, iOp, iA, iB,
    input  oReady, oValid, oALU, oHi, oLo, oZero, oOverflow, oDivZero
  );

  modport slave (
    input  iValid, iOp, iA, iB,
    output oReady, oValid, oALU, oHi, oLo, oZero, oOverflow, oDivZero
  );
endinterface

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: iterative unsigned multiply / restoring divide engine.
//   iClk, iReset_n : clock, synchronous active-low reset
//   start_i        : load operands and perform the first step
//   is_div_i       : 1 = divide, 0 = multiply
//   a_mag_i        : multiplier / dividend magnitude
//   b_mag_i        : multiplicand / divisor magnitude
//   done_o         : high during the cycle whose edge performs the last step
//   hi_o, lo_o     : product high/low word, or remainder/quotient
// The accumulator is {hi, lo}. The start edge performs step 1, so the
// counter loaded with DATA_W-1 covers the remaining steps.
module alu_mdu_iter #(
  parameter int DATA_W = 32
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              start_i,
  input  logic              is_div_i,
  input  logic [DATA_W-1:0] a_mag_i,
  input  logic [DATA_W-1:0] b_mag_i,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic                div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;

  // One shift-add (multiply) or shift-subtract (divide) step.
  function automatic logic [2*DATA_W-1:0] mdu_step(
    input logic [2*DATA_W-1:0] acc,
    input logic [DATA_W-1:0]   opnd,
    input logic                div
  );
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W:0]   sum;
    logic [DATA_W+1:0] diff;
    hi   = acc[2*DATA_W-1:DATA_W];
    lo   = acc[DATA_W-1:0];
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
    // Extra top bit catches the borrow of the trial subtraction.
    diff = {1'b0, hi, lo[DATA_W-1]} - {2'b00, opnd};
    if (!div)
      mdu_step = {sum, lo[DATA_W-1:1]};
    else if (!diff[DATA_W+1])
      mdu_step = {diff[DATA_W-1:0], lo[DATA_W-2:0], 1'b1};
    else
      mdu_step = {hi[DATA_W-2:0], lo, 1'b0};
  endfunction

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      acc_d  = mdu_step({{DATA_W{1'b0}}, a_mag_i}, b_mag_i, is_div_i);
      opnd_d = b_mag_i;
      div_d  = is_div_i;
      cnt_d  = CNT_W'(DATA_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = mdu_step(acc_q, opnd_q, div_q);
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1))
        busy_d = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_W'(1));
  assign hi_o   = acc_q[2*DATA_W-1:DATA_W];
  assign lo_o   = acc_q[DATA_W-1:0];

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS EX-stage ALU with HI/LO multiply/divide.
//   iClk, iReset_n : clock, synchronous active-low reset
//   bus (slave)    : request handshake, operands, registered results/flags
//
// state    | meaning
// ST_IDLE  | ready; single-cycle ops complete on the accept edge
// ST_ITER  | alu_mdu_iter stepping through the multiply/divide
// ST_FIX   | sign correction / divide-by-zero result, load HI/LO/oALU
module alu_mc
  import alu_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input logic     iClk,
  input logic     iReset_n,
  alu_mc_if.slave bus
);
  logic [DATA_W-1:0] a, b;
  logic [OP_W-1:0]   op;
  assign a  = bus.iA;
  assign b  = bus.iB;
  assign op = bus.iOp;

  logic [1:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] alu_q, alu_d, hi_q, hi_d, lo_q, lo_d;
  logic              zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic              div_q, div_d, dz_pend_q, dz_pend_d;
  logic [DATA_W-1:0] a_q, a_d;

  // Single-cycle datapath
  logic [DATA_W-1:0] add_res, sub_res, sc_res;
  logic              sc_ovf, sc_def;
  assign add_res = a + b;
  assign sub_res = a - b;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_def = 1'b1;
    case (op)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_ADD: begin
        sc_res = add_res;
        sc_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (add_res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        sc_res = sub_res;
        sc_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (sub_res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SLT:  sc_res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_res = {{(DATA_W-1){1'b0}}, a < b};
      default: sc_def = 1'b0;
    endcase
  end

  // Sign pre-processing: signed ops iterate on magnitudes. The most
  // negative value negates to itself, which is its correct unsigned magnitude.
  logic              is_md, is_div, is_signed;
  logic [DATA_W-1:0] a_mag, b_mag;
  assign is_md     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag     = (is_signed && a[DATA_W-1]) ? -a : a;
  assign b_mag     = (is_signed && b[DATA_W-1]) ? -b : b;

  logic              mdu_start, mdu_done;
  logic [DATA_W-1:0] mdu_hi, mdu_lo;

  alu_mdu_iter #(.DATA_W(DATA_W)) u_mdu (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .start_i  (mdu_start),
    .is_div_i (is_div),
    .a_mag_i  (a_mag),
    .b_mag_i  (b_mag),
    .done_o   (mdu_done),
    .hi_o     (mdu_hi),
    .lo_o     (mdu_lo)
  );

  // Sign post-processing
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  assign prod     = {mdu_hi, mdu_lo};
  assign prod_fix = neg_quo_q ? -prod : prod;
  assign quo_fix  = neg_quo_q ? -mdu_lo : mdu_lo;
  assign rem_fix  = neg_rem_q ? -mdu_hi : mdu_hi;

  always_comb begin
    state_d   = state_q;
    valid_d   = 1'b0;
    alu_d     = alu_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div_d     = div_q;
    dz_pend_d = dz_pend_q;
    a_d       = a_q;
    mdu_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.iValid) begin
          if (is_md) begin
            neg_quo_d = is_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
            neg_rem_d = is_signed && a[DATA_W-1];
            div_d     = is_div;
            a_d       = a;
            if (is_div && (b == '0)) begin
              dz_pend_d = 1'b1;
              state_d   = ST_FIX;
            end else begin
              dz_pend_d = 1'b0;
              mdu_start = 1'b1;
              state_d   = ST_ITER;
            end
          end else begin
            valid_d = 1'b1;
            alu_d   = sc_res;
            zero_d  = sc_def && (sc_res == '0);
            ovf_d   = sc_ovf;
            dz_d    = 1'b0;
          end
        end
      end
      ST_ITER: begin
        if (mdu_done)
          state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        valid_d = 1'b1;
        ovf_d   = 1'b0;
        dz_d    = dz_pend_q;
        if (dz_pend_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end
        alu_d  = lo_d;
        zero_d = (lo_d == '0);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      alu_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_q     <= 1'b0;
      dz_pend_q <= 1'b0;
      a_q       <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      alu_q     <= alu_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div_q     <= div_d;
      dz_pend_q <= dz_pend_d;
      a_q       <= a_d;
    end
  end

  assign bus.oReady    = (state_q == ST_IDLE);
  assign bus.oValid    = valid_q;
  assign bus.oALU      = alu_q;
  assign bus.oHi       = hi_q;
  assign bus.oLo       = lo_q;
  assign bus.oZero     = zero_q;
  assign bus.oOverflow = ovf_q;
  assign bus.oDivZero  = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  import alu_defs::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_mc_if #(.DATA_W(32), .OP_W(4)) bus ();

  alu_mc #(.DATA_W(32), .OP_W(4)) u_dut (
    .iClk     (clk),
    .iReset_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu;
    logic        ovf;
    logic        zero;
    logic        chk_zero;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat, input logic exp_dz);
    int lat;
    int low;
    bus.iValid = 1'b1;
    bus.iOp    = op;
    bus.iA     = a;
    bus.iB     = b;
    tick();
    // Operands must have been captured on the accept edge.
    bus.iValid = 1'b0;
    bus.iOp    = OP_ADD;
    bus.iA     = 32'hDEADBEEF;
    bus.iB     = 32'h0;
    lat = 1;
    low = 0;
    while (!bus.oValid && lat < 100) begin
      if (!bus.oReady) low++;
      tick();
      lat++;
    end
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " ready-low cycles"}, low, exp_lat - 1);
    chk({name, " HI"}, bus.oHi, exp_hi);
    chk({name, " LO"}, bus.oLo, exp_lo);
    chk({name, " ALU"}, bus.oALU, exp_lo);
    chk({name, " divzero"}, {31'b0, bus.oDivZero}, {31'b0, exp_dz});
    chk({name, " zero"}, {31'b0, bus.oZero}, {31'b0, exp_lo == 32'h0});
    chk({name, " ready at valid"}, {31'b0, bus.oReady}, 32'h1);
    tick();
    chk({name, " valid pulse ends"}, {31'b0, bus.oValid}, 32'h0);
  endtask

  initial begin
    int stray;
    n_checks = 0;
    n_errors = 0;

    //          op        a             b             alu           ovf   zero  chk_zero
    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{OP_OR,   32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{OP_XOR,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{OP_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{OP_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{4'd12,   32'h00000005, 32'h00000007, 32'h00000000, 1'b0, 1'b0, 1'b0};

    rst_n      = 1'b0;
    bus.iValid = 1'b0;
    bus.iOp    = OP_AND;
    bus.iA     = 32'h0;
    bus.iB     = 32'h0;
    tick();
    tick();
    chk("reset valid", {31'b0, bus.oValid}, 32'h0);
    chk("reset ready", {31'b0, bus.oReady}, 32'h1);
    chk("reset ALU", bus.oALU, 32'h0);
    chk("reset HI", bus.oHi, 32'h0);
    chk("reset LO", bus.oLo, 32'h0);
    chk("reset flags", {29'b0, bus.oZero, bus.oOverflow, bus.oDivZero}, 32'h0);
    rst_n = 1'b1;

    // Back-to-back single-cycle requests: one oValid per accepted request.
    for (int i = 0; i < 13; i++) begin
      bus.iValid = 1'b1;
      bus.iOp    = vecs[i].op;
      bus.iA     = vecs[i].a;
      bus.iB     = vecs[i].b;
      tick();
      chk($sformatf("vec%0d valid", i), {31'b0, bus.oValid}, 32'h1);
      chk($sformatf("vec%0d ALU", i), bus.oALU, vecs[i].alu);
      chk($sformatf("vec%0d overflow", i), {31'b0, bus.oOverflow}, {31'b0, vecs[i].ovf});
      if (vecs[i].chk_zero)
        chk($sformatf("vec%0d zero", i), {31'b0, bus.oZero}, {31'b0, vecs[i].zero});
    end
    bus.iValid = 1'b0;
    chk("single-cycle HI unchanged", bus.oHi, 32'h0);
    chk("single-cycle LO unchanged", bus.oLo, 32'h0);
    tick();
    chk("single-cycle valid drops", {31'b0, bus.oValid}, 32'h0);

    run_md("MULT",        OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 33, 1'b0);
    run_md("MULTU",       OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 33, 1'b0);
    run_md("DIV -7/2",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
    run_md("DIV min/-1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0);
    run_md("DIVU 100/7",  OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 33, 1'b0);
    run_md("MULTU 2^32",  OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33, 1'b0);
    run_md("DIVU 9/0",    OP_DIVU,  32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF, 2,  1'b1);

    bus.iValid = 1'b1;
    bus.iOp    = OP_ADD;
    bus.iA     = 32'h1;
    bus.iB     = 32'h2;
    tick();
    bus.iValid = 1'b0;
    chk("ADD after div0 ALU", bus.oALU, 32'h3);
    chk("ADD clears divzero", {31'b0, bus.oDivZero}, 32'h0);

    // Reset in the middle of an iterative multiply.
    bus.iValid = 1'b1;
    bus.iOp    = OP_MULTU;
    bus.iA     = 32'h7;
    bus.iB     = 32'h5;
    tick();
    bus.iValid = 1'b0;
    repeat (9) tick();
    chk("busy before abort", {31'b0, bus.oReady}, 32'h0);
    rst_n      = 1'b0;
    bus.iValid = 1'b1;
    bus.iOp    = OP_ADD;
    bus.iA     = 32'h1;
    bus.iB     = 32'h1;
    tick();
    rst_n = 1'b1;
    chk("abort valid", {31'b0, bus.oValid}, 32'h0);
    chk("abort ready", {31'b0, bus.oReady}, 32'h1);
    chk("abort ALU", bus.oALU, 32'h0);
    chk("abort HI", bus.oHi, 32'h0);
    chk("abort LO", bus.oLo, 32'h0);
    chk("abort flags", {29'b0, bus.oZero, bus.oOverflow, bus.oDivZero}, 32'h0);
    bus.iOp = OP_AND;
    bus.iA  = 32'h0000000F;
    bus.iB  = 32'h00000003;
    tick();
    bus.iValid = 1'b0;
    chk("AND after abort valid", {31'b0, bus.oValid}, 32'h1);
    chk("AND after abort ALU", bus.oALU, 32'h3);
    stray = 0;
    repeat (40) begin
      tick();
      if (bus.oValid) stray++;
    end
    chk("no oValid from aborted op", stray, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
